// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: state enum,
// instruction-class flag bundle and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    // One-hot instruction-class flags as delivered by the opcode decoder.
    typedef struct packed {
        logic rt;
        logic addi;
        logic andi;
        logic lw;
        logic sw;
        logic j;
        logic jal;
        logic jr;
        logic beq;
        logic bne;
    } cls_t;

    // Register-file destination select.
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Register-file write-data select.
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // ALU operation.
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_AND   = 2'd3;

    // PC source select.
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // True when exactly one class flag is set.
    function automatic logic one_hot(input cls_t c);
        logic [9:0] v;
        v = c;
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Combinational state -> control decoder for the multi-cycle controller.
// Enables that depend on handshakes or the branch outcome are resolved here.
module mc_ctrl_out
    import mc_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  cls_t       cls,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] mem2reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    // Decode the current state into datapath enables and selects.
    always_comb begin
        // NOTE: every output is given a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        pc_wr      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = REG_DST_RT;
        mem2reg    = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_wr     = mem_rdy;
                pc_wr     = mem_rdy;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = SRCB_IMM_SH;
                if (!one_hot(cls)) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                reg_dst    = REG_DST_RT;
                mem2reg    = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_wr     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_rdy;
            end
            S_RTEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                reg_wr     = 1'b1;
                reg_dst    = REG_DST_RD;
                instr_done = 1'b1;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = cls.andi ? ALU_AND : ALU_ADD;
            end
            S_IWB: begin
                reg_wr     = 1'b1;
                reg_dst    = REG_DST_RT;
                instr_done = 1'b1;
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_B;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_wr      = (cls.beq & zero) | (cls.bne & ~zero);
                instr_done = 1'b1;
            end
            S_JMP: begin
                pc_src     = PC_JUMP;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // Old PC (already PC+4) lands in $31 on the same edge the PC loads.
                reg_wr     = 1'b1;
                reg_dst    = REG_DST_RA;
                mem2reg    = M2R_PC;
                pc_src     = PC_JUMP;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = PC_REG;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset suppresses every write and parks the selects at FETCH values.
        if (rst) begin
            pc_wr      = 1'b0;
            iord       = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = REG_DST_RT;
            mem2reg    = M2R_ALUOUT;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALU_ADD;
            pc_src     = PC_ALU;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: state register and next-state sequencing;
// output decoding lives in mc_ctrl_out.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       RT,
    input  logic       addi,
    input  logic       andi,
    input  logic       lw,
    input  logic       sw,
    input  logic       j,
    input  logic       jal,
    input  logic       jr,
    input  logic       beq,
    input  logic       bne,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] mem2reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t state;
    state_t next_state;
    cls_t   cls;

    assign cls = {RT, addi, andi, lw, sw, j, jal, jr, beq, bne};

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its inputs from before the clock edge.
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Next-state sequencing through fetch/decode/execute/memory/write-back.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!one_hot(cls))          next_state = S_FETCH;
                else if (cls.lw || cls.sw)  next_state = S_MEMADR;
                else if (cls.rt)            next_state = S_RTEXE;
                else if (cls.addi || cls.andi) next_state = S_IEXE;
                else if (cls.beq || cls.bne)   next_state = S_BR;
                else if (cls.j)             next_state = S_JMP;
                else if (cls.jal)           next_state = S_JAL;
                else                        next_state = S_JR;
            end
            S_MEMADR: next_state = cls.lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTEXE:  next_state = S_RTWB;
            S_IEXE:   next_state = S_IWB;
            default:  next_state = S_FETCH;
        endcase
    end

    mc_ctrl_out u_out (
        .rst        (rst),
        .state      (state),
        .cls        (cls),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .pc_wr      (pc_wr),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction class is described as a
// list of micro-steps, and every cycle's full control vector is compared.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_wr;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem2reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    // Micro-steps of an instruction.
    localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MWB = 4, K_MW = 5,
                   K_RE = 6, K_RW = 7, K_IE = 8, K_IW = 9, K_BR = 10,
                   K_J = 11, K_JAL = 12, K_JR = 13;

    // Flag vectors in {RT, addi, andi, lw, sw, j, jal, jr, beq, bne} order.
    localparam logic [9:0] F_RT   = 10'b10_0000_0000;
    localparam logic [9:0] F_ADDI = 10'b01_0000_0000;
    localparam logic [9:0] F_ANDI = 10'b00_1000_0000;
    localparam logic [9:0] F_LW   = 10'b00_0100_0000;
    localparam logic [9:0] F_SW   = 10'b00_0010_0000;
    localparam logic [9:0] F_J    = 10'b00_0001_0000;
    localparam logic [9:0] F_JAL  = 10'b00_0000_1000;
    localparam logic [9:0] F_JR   = 10'b00_0000_0100;
    localparam logic [9:0] F_BEQ  = 10'b00_0000_0010;
    localparam logic [9:0] F_BNE  = 10'b00_0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       RT, addi, andi, lw, sw, j, jal, jr, beq, bne;
    logic       zero, mem_rdy;
    logic       pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_wr;
    logic [1:0] reg_dst, mem2reg, alu_src_b, alu_op, pc_src;
    logic       alu_src_a, instr_done, illegal;
    ctl_t       got;

    int n_cmp = 0;
    int n_bad = 0;
    int instr_no = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst),
        .RT(RT), .addi(addi), .andi(andi), .lw(lw), .sw(sw),
        .j(j), .jal(jal), .jr(jr), .beq(beq), .bne(bne),
        .zero(zero), .mem_rdy(mem_rdy),
        .pc_wr(pc_wr), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem2reg(mem2reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal)
    );

    assign got = {pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst, mem2reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected control vector for one micro-step.
    function automatic ctl_t model(input int k, input logic [9:0] f,
                                   input logic z, input logic rdy);
        ctl_t c;
        c = '0;
        case (k)
            K_F:   begin c.mem_rd = 1; c.alu_src_b = 2'd1; c.ir_wr = rdy; c.pc_wr = rdy; end
            K_D:   begin
                c.alu_src_b = 2'd3;
                if ($countones(f) != 1) begin c.illegal = 1; c.instr_done = 1; end
            end
            K_MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            K_MR:  begin c.mem_rd = 1; c.iord = 1; end
            K_MWB: begin c.reg_wr = 1; c.mem2reg = 2'd1; c.instr_done = 1; end
            K_MW:  begin c.mem_wr = 1; c.iord = 1; c.instr_done = rdy; end
            K_RE:  begin c.alu_src_a = 1; c.alu_op = 2'd2; end
            K_RW:  begin c.reg_wr = 1; c.reg_dst = 2'd1; c.instr_done = 1; end
            K_IE:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = (f == F_ANDI) ? 2'd3 : 2'd0; end
            K_IW:  begin c.reg_wr = 1; c.instr_done = 1; end
            K_BR:  begin
                c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.instr_done = 1;
                c.pc_wr = (f == F_BEQ) ? z : ~z;
            end
            K_J:   begin c.pc_src = 2'd2; c.pc_wr = 1; c.instr_done = 1; end
            K_JAL: begin
                c.reg_wr = 1; c.reg_dst = 2'd2; c.mem2reg = 2'd2;
                c.pc_src = 2'd2; c.pc_wr = 1; c.instr_done = 1;
            end
            K_JR:  begin c.pc_src = 2'd3; c.pc_wr = 1; c.instr_done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Expected vector while reset is asserted: no writes, FETCH selects.
    function automatic ctl_t reset_exp();
        ctl_t c;
        c = '0;
        c.alu_src_b = 2'd1;
        return c;
    endfunction

    // Run one instruction. rdy_mode: 0 always ready, 1 random stalls,
    // 2 two stall cycles in the memory step. zero_mode: 0/1 fixed, 2 random.
    // abort_at >= 0 asserts reset in that step and abandons the instruction.
    task automatic run_instr(input logic [9:0] f, input int rdy_mode,
                             input int zero_mode, input int abort_at);
        int   steps[$];
        int   streak;
        int   in_step;
        logic adv;
        instr_no++;
        steps.push_back(K_F);
        steps.push_back(K_D);
        if ($countones(f) == 1) begin
            case (f)
                F_LW:   begin steps.push_back(K_MA); steps.push_back(K_MR); steps.push_back(K_MWB); end
                F_SW:   begin steps.push_back(K_MA); steps.push_back(K_MW); end
                F_RT:   begin steps.push_back(K_RE); steps.push_back(K_RW); end
                F_ADDI, F_ANDI: begin steps.push_back(K_IE); steps.push_back(K_IW); end
                F_BEQ, F_BNE:   steps.push_back(K_BR);
                F_J:    steps.push_back(K_J);
                F_JAL:  steps.push_back(K_JAL);
                default: steps.push_back(K_JR);
            endcase
        end
        streak = 0;
        for (int i = 0; i < steps.size(); i++) begin
            in_step = 0;
            do begin
                @(negedge clk);
                {RT, addi, andi, lw, sw, j, jal, jr, beq, bne} = f;
                zero = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
                case (rdy_mode)
                    0: mem_rdy = 1'b1;
                    1: mem_rdy = (streak >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    default: mem_rdy = (steps[i] == K_MR || steps[i] == K_MW) ? (in_step >= 2) : 1'b1;
                endcase
                streak = mem_rdy ? 0 : streak + 1;
                if (i == abort_at) begin
                    rst = 1'b1;
                    #1 check($sformatf("abort i%0d s%0d", instr_no, i), got, reset_exp());
                    @(posedge clk);
                    #1 rst = 1'b0;
                    return;
                end
                #1 check($sformatf("i%0d s%0d k%0d", instr_no, i, steps[i]), got,
                         model(steps[i], f, zero, mem_rdy));
                adv = !(steps[i] == K_F || steps[i] == K_MR || steps[i] == K_MW) || mem_rdy;
                in_step++;
            end while (!adv);
        end
    endtask

    initial begin
        logic [9:0] f;
        rst = 1'b1;
        mem_rdy = 1'b1;
        zero = 1'b0;
        {RT, addi, andi, lw, sw, j, jal, jr, beq, bne} = F_LW;
        repeat (3) begin
            @(negedge clk);
            #1 check("reset", got, reset_exp());
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases.
        run_instr(F_LW,  0, 2, -1);
        run_instr(F_SW,  2, 2, -1);
        run_instr(F_BEQ, 0, 1, -1);
        run_instr(F_BEQ, 0, 0, -1);
        run_instr(F_BNE, 0, 0, -1);
        run_instr(F_BNE, 0, 1, -1);
        run_instr(F_JAL, 0, 2, -1);
        run_instr(10'd0, 0, 2, -1);
        run_instr(F_RT | F_LW, 0, 2, -1);
        run_instr(F_ANDI, 0, 2, -1);
        run_instr(F_ADDI, 0, 2, -1);
        run_instr(F_RT, 2, 2, -1);
        run_instr(F_J,  0, 2, -1);
        run_instr(F_JR, 0, 2, -1);
        run_instr(F_LW, 2, 2, -1);

        // Reset mid-instruction, then a clean instruction from FETCH.
        run_instr(F_LW,  0, 2, 3);
        run_instr(F_SW,  0, 2, -1);
        run_instr(F_JAL, 0, 2, 2);
        run_instr(F_RT,  0, 2, -1);

        // Random traffic with random stalls and a few malformed flag sets.
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) f = 10'($urandom);
            else                            f = 10'b1 << $urandom_range(0, 9);
            run_instr(f, 1, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS-subset core. It consumes the one-hot instruction-class flags from the opcode decoder, plus the ALU zero flag and a memory-ready handshake. It sequences every instruction through fetch, decode, execute, memory and write-back states, and drives all datapath enables and mux selects. It sits between the opcode decoder and the shared-memory multi-cycle datapath.

## Interface
- No parameters; all encodings are fixed in `mc_ctrl_pkg`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RT, addi, andi, lw, sw, j, jal, jr, beq, bne` in 1 each: one-hot class flags from the opcode decoder, valid while IR is stable.
- `zero` in 1: ALU zero flag, combinational in the same cycle.
- `mem_rdy` in 1: memory has completed the current read or write this cycle.
- `pc_wr` out 1: PC load enable, with branch condition already resolved.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_rd`, `mem_wr` out 1 each: memory read and write strobes.
- `ir_wr` out 1: IR load enable.
- `reg_wr` out 1: register-file write enable.
- `reg_dst` out 2: destination select; 0 = rt, 1 = rd, 2 = $31.
- `mem2reg` out 2: write-data select; 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select; 0 = B, 1 = 4, 2 = sext(imm), 3 = sext(imm)<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 funct-directed, 11 and.
- `pc_src` out 2: PC source; 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse in DECODE when the class flags are not exactly one-hot.

## Operation
- States, 4-bit encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, IEXE 8, IWB 9, BR 10, JMP 11, JAL 12, JR 13.
- Unlisted outputs are 0 in every state.
- **FETCH**
  - Drives mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
  - ir_wr and pc_wr equal mem_rdy.
  - Stays in FETCH while mem_rdy=0; goes to DECODE when mem_rdy=1.
- **DECODE**
  - Drives alu_src_a=0, alu_src_b=3, add (branch target into ALUOut).
  - Next state: lw/sw→MEMADR, RT→RTEXE, addi/andi→IEXE, beq/bne→BR, j→JMP, jal→JAL, jr→JR.
  - If zero or more than one flag is set: illegal=1, instr_done=1, next state FETCH (instruction treated as NOP).
- **MEMADR**: alu_src_a=1, alu_src_b=2, add. Goes to MEMRD if lw, else MEMWR.
- **MEMRD**: mem_rd=1, iord=1. Holds until mem_rdy=1, then goes to MEMWB.
- **MEMWB**: reg_wr=1, reg_dst=0, mem2reg=1, instr_done=1, then FETCH.
- **MEMWR**: mem_wr=1, iord=1. Holds until mem_rdy; instr_done=mem_rdy; then FETCH.
- **RTEXE**: alu_src_a=1, alu_src_b=0, alu_op=10, then RTWB.
- **RTWB**: reg_wr=1, reg_dst=1, mem2reg=0, instr_done=1, then FETCH.
- **IEXE**: alu_src_a=1, alu_src_b=2. alu_op=add for addi, and for andi. Then IWB.
- **IWB**: reg_wr=1, reg_dst=0, mem2reg=0, instr_done=1, then FETCH.
- **BR**
  - Drives alu_src_a=1, alu_src_b=0, sub, pc_src=1.
  - pc_wr = (beq & zero) | (bne & ~zero).
  - instr_done=1, then FETCH.
- **JMP**: pc_src=2, pc_wr=1, instr_done=1, then FETCH.
- **JAL**
  - Drives reg_wr=1, reg_dst=2, mem2reg=2, pc_src=2, pc_wr=1, instr_done=1, then FETCH.
  - The register file captures the old PC (already PC+4) on the same edge the PC loads.
- **JR**: pc_src=3, pc_wr=1, instr_done=1, then FETCH.
- Class flags are sampled only in DECODE and in the states that branch on them. IR does not change outside FETCH, so the flags are stable there.

## Timing
- Reset: while rst=1, next state is FETCH and pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, instr_done and illegal are all forced to 0.
- Selects during reset are don't-care, driven to the FETCH values.
- First fetch strobe appears in the first cycle after rst falls.
- Reset mid-instruction: abandons the instruction and suppresses any write in that cycle.
- Cycle counts with mem_rdy always 1:
  - lw: 5.
  - sw, R-type, addi, andi: 4.
  - beq, bne, j, jal, jr: 3.
  - Each cycle of mem_rdy=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs are combinational from state plus mem_rdy, zero and the class flags. State is registered.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum;
  - the localparams for reg_dst, mem2reg, alu_src_b, alu_op and pc_src encodings.
- Sub-module `mc_ctrl_out`: purely combinational state→control decoder. `mc_ctrl` keeps the state register and the next-state logic.

## Test plan
- rst held 3 cycles, then released with mem_rdy=1 → all enables 0 during reset; mem_rd=1, ir_wr=1, pc_wr=1 in the first cycle after release.
- lw flag, mem_rdy=1 → states 0,1,2,3,4; in state 4 reg_wr=1, mem2reg=1, instr_done=1; 5 cycles total.
- sw flag, mem_rdy low 2 cycles in MEMWR → mem_wr held 3 cycles, instr_done only on the mem_rdy=1 cycle.
- beq with zero=1 then beq with zero=0; bne with zero=0 → pc_wr=1, 0, 1 respectively in BR, pc_src=1 each time.
- jal → JAL cycle has reg_dst=2, mem2reg=2, pc_src=2, reg_wr=1, pc_wr=1 together.
- DECODE with flags 0 and with RT+lw both set → illegal=1 for one cycle, no reg_wr or mem_wr, next state FETCH.
